// File: rtl/sub_top_video_clkgen_nco.sv
// Multi-channel NCO clock generator: per-channel phase accumulators produce wrap
// strobes and divided clocks, with a settle/lock sequencer gating run-time reprogramming.
module sub_top_video_clkgen_nco #(
  parameter int                        NUM_CH        = 3,
  parameter int                        ACC_W         = 32,
  parameter int                        SETTLE_CYCLES = 1024,
  parameter logic [NUM_CH*ACC_W-1:0]   INIT_INC      = '0,
  parameter int                        CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] outclk_en,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  // state     | meaning
  // ST_SETTLE | counting settle cycles, locked=0, config port closed
  // ST_LOCKED | all channels stable, locked=1, config port open
  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int              CNT_W      = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] L_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CH_W:0]   L_NUM_CH   = (CH_W + 1)'(NUM_CH);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_ch_ok;
  logic             w_apply;

  assign w_accept = cfg_valid && (r_state == ST_LOCKED);
  assign w_ch_ok  = ({1'b0, cfg_ch} < L_NUM_CH);
  // Out-of-range writes are consumed but leave everything untouched.
  assign w_apply  = w_accept && w_ch_ok;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SETTLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_cnt == L_CNT_LAST) begin
            r_state <= ST_LOCKED;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_apply) begin
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_SETTLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign locked    = (r_state == ST_LOCKED);
  assign cfg_ready = (r_state == ST_LOCKED);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] L_IDX = CH_W'(i);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic             r_en;
    logic             r_outclk;
    logic             r_outclk_en;
    logic [ACC_W:0]   w_sum;
    logic             w_hit;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_hit = w_apply && (cfg_ch == L_IDX);

    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc       <= '0;
        r_inc       <= INIT_INC[i*ACC_W +: ACC_W];
        r_en        <= 1'b1;
        r_outclk    <= 1'b0;
        r_outclk_en <= 1'b0;
      end else if (w_hit) begin
        // Reprogrammed channel restarts from phase zero.
        r_acc       <= '0;
        r_inc       <= cfg_inc;
        r_en        <= cfg_en;
        r_outclk    <= 1'b0;
        r_outclk_en <= 1'b0;
      end else if (r_en) begin
        r_acc       <= w_sum[ACC_W-1:0];
        r_outclk_en <= w_sum[ACC_W];
        r_outclk    <= w_sum[ACC_W-1];
      end else begin
        r_outclk    <= 1'b0;
        r_outclk_en <= 1'b0;
      end
    end

    assign outclk[i]    = r_outclk;
    assign outclk_en[i] = r_outclk_en;
  end

endmodule

// File: tb/tb_sub_top_video_clkgen_nco.sv
// Self-checking bench for sub_top_video_clkgen_nco against an arithmetic reference model.
module tb_sub_top_video_clkgen_nco;

  localparam int NCH  = 3;
  localparam int AW   = 8;
  localparam int SC   = 16;
  localparam int MOD  = 256;
  localparam int HALF = 128;

  logic           refclk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic [AW-1:0]  cfg_inc = '0;
  logic           cfg_en = 1'b0;
  logic [NCH-1:0] outclk_en;
  logic [NCH-1:0] outclk;
  logic           locked;

  int n_cmp = 0;
  int n_err = 0;

  int m_acc [NCH];
  int m_inc [NCH];
  int m_en  [NCH];
  int m_oc  [NCH];
  int m_oe  [NCH];
  int m_since;
  bit m_accepted;
  int init_inc [NCH] = '{64, 128, 0};

  sub_top_video_clkgen_nco #(
    .NUM_CH(NCH), .ACC_W(AW), .SETTLE_CYCLES(SC), .INIT_INC({8'd0, 8'd128, 8'd64})
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_en(cfg_en),
    .outclk_en(outclk_en), .outclk(outclk), .locked(locked)
  );

  always #5 refclk = ~refclk;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = 0; m_inc[i] = init_inc[i]; m_en[i] = 1; m_oc[i] = 0; m_oe[i] = 0;
    end
    m_since = 0;
    m_accepted = 1'b0;
  endfunction

  // Next state from phase arithmetic: output frequency = inc/2^AW of refclk.
  function automatic void model_step();
    bit take;
    int s;
    take = cfg_valid && (m_since >= SC);
    m_accepted = take;
    for (int i = 0; i < NCH; i++) begin
      if (take && (int'(cfg_ch) == i)) begin
        m_acc[i] = 0; m_oc[i] = 0; m_oe[i] = 0;
        m_inc[i] = int'(cfg_inc); m_en[i] = int'(cfg_en);
      end else if (m_en[i] != 0) begin
        s = m_acc[i] + m_inc[i];
        m_oe[i]  = (s >= MOD) ? 1 : 0;
        m_acc[i] = s % MOD;
        m_oc[i]  = (m_acc[i] >= HALF) ? 1 : 0;
      end else begin
        m_oe[i] = 0; m_oc[i] = 0;
      end
    end
    if (take && (int'(cfg_ch) < NCH)) m_since = 0;
    else if (m_since < SC) m_since++;
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < NCH; i++) begin
      e[5+i] = (m_oe[i] != 0);
      e[2+i] = (m_oc[i] != 0);
    end
    e[1] = (m_since >= SC);
    e[0] = (m_since >= SC);
    return e;
  endfunction

  function automatic logic [7:0] dut_vec();
    return {outclk_en, outclk, locked, cfg_ready};
  endfunction

  task automatic tick();
    @(posedge refclk);
    model_step();
    @(negedge refclk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge refclk);
    model_reset();
    n_cmp++;
    if (dut_vec() !== 8'h00) begin
      n_err++; $display("FAIL reset_values: got %b exp %b", dut_vec(), 8'h00);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= SC; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_release edge %0d: got %b exp %b", k, dut_vec(), exp_vec());
      end
      n_cmp++;
      if (locked !== (k == SC)) begin
        n_err++; $display("FAIL lock_edge %0d: got %b exp %b", k, locked, (k == SC));
      end
    end
  endtask

  task automatic test_init_patterns();
    int oe0 = 0, oe1 = 0, hi0 = 0, tog1 = 0, any2 = 0;
    logic prev1;
    prev1 = outclk[1];
    for (int k = 0; k < 16; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL init_pattern cyc %0d: got %b exp %b", k, dut_vec(), exp_vec());
      end
      oe0 += int'(outclk_en[0]); oe1 += int'(outclk_en[1]); hi0 += int'(outclk[0]);
      if (outclk[1] !== prev1) tog1++;
      prev1 = outclk[1];
      if (outclk[2] || outclk_en[2]) any2++;
    end
    n_cmp++;
    if (oe0 != 4 || hi0 != 8) begin
      n_err++; $display("FAIL ch0_quarter: got strobes %0d highs %0d exp 4 8", oe0, hi0);
    end
    n_cmp++;
    if (oe1 != 8 || tog1 != 16) begin
      n_err++; $display("FAIL ch1_half: got strobes %0d toggles %0d exp 8 16", oe1, tog1);
    end
    n_cmp++;
    if (any2 != 0) begin
      n_err++; $display("FAIL ch2_zero_inc: got %0d active cycles exp 0", any2);
    end
  endtask

  task automatic test_write_ch2();
    int lows = 0, oe2 = 0, hi2 = 0;
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 8'd32; cfg_en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_ready !== 1'b0 || locked !== 1'b0) begin
      n_err++; $display("FAIL write_ch2_drop: got ready %b locked %b exp 0 0", cfg_ready, locked);
    end
    lows += int'(!locked);
    for (int k = 1; k <= SC; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL write_ch2 cyc %0d: got %b exp %b", k, dut_vec(), exp_vec());
      end
      lows += int'(!locked); oe2 += int'(outclk_en[2]); hi2 += int'(outclk[2]);
    end
    n_cmp++;
    if (lows != SC || oe2 != 2 || hi2 != 8) begin
      n_err++; $display("FAIL ch2_eighth: got lows %0d strobes %0d highs %0d exp 16 2 8", lows, oe2, hi2);
    end
  endtask

  task automatic test_disable_ch0();
    int bad = 0;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd64; cfg_en = 1'b0;
    tick();
    cfg_valid = 1'b0;
    for (int k = 0; k < SC; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL disable_ch0 cyc %0d: got %b exp %b", k, dut_vec(), exp_vec());
      end
      if (outclk[0] || outclk_en[0]) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL ch0_held: got %0d active cycles exp 0", bad);
    end
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd64; cfg_en = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int k = 0; k < SC; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reenable_ch0 cyc %0d: got %b exp %b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_out_of_range();
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 8'd255; cfg_en = 1'b0;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (locked !== 1'b1 || cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL out_of_range_lock: got locked %b ready %b exp 1 1", locked, cfg_ready);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL out_of_range cyc %0d: got %b exp %b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_hold_during_settle();
    int taken_at = -1;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 8'd64; cfg_en = 1'b1;
    tick();
    cfg_ch = 2'd2; cfg_inc = 8'd16; cfg_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL hold_settle cyc %0d: got %b exp %b", k, dut_vec(), exp_vec());
      end
      if (m_accepted) begin
        taken_at = k;
        break;
      end
    end
    cfg_valid = 1'b0;
    n_cmp++;
    if (taken_at != SC + 1) begin
      n_err++; $display("FAIL hold_accept_edge: got %0d exp %0d", taken_at, SC + 1);
    end
    n_cmp++;
    if (locked !== 1'b0) begin
      n_err++; $display("FAIL hold_relock_drop: got %b exp 0", locked);
    end
  endtask

  task automatic test_async_reset();
    repeat (3) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL pre_reset: got %b exp %b", dut_vec(), exp_vec());
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== 8'h00) begin
      n_err++; $display("FAIL async_reset: got %b exp %b", dut_vec(), 8'h00);
    end
    model_reset();
    @(negedge refclk);
    rst_n = 1'b1;
    for (int k = 1; k <= SC + 8; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL post_reset cyc %0d: got %b exp %b", k, dut_vec(), exp_vec());
      end
      if (k <= SC) begin
        n_cmp++;
        if (locked !== (k == SC)) begin
          n_err++; $display("FAIL post_reset_lock edge %0d: got %b exp %b", k, locked, (k == SC));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if (!cfg_valid && $urandom_range(0, 11) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = 2'($urandom_range(0, 3));
        cfg_inc   = 8'($urandom_range(0, 255));
        cfg_en    = ($urandom_range(0, 4) != 0);
      end
      tick();
      if (m_accepted) cfg_valid = 1'b0;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random cyc %0d: got %b exp %b", k, dut_vec(), exp_vec());
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init_patterns();
    test_write_ch2();
    test_disable_ch0();
    test_out_of_range();
    test_hold_during_settle();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sub_top_video_clkgen_nco.md
Name: sub_top_video_clkgen_nco

Overview:
- Parametrised, fully digital successor to the fixed three-output video clock source.
- Generates NUM_CH independent clock-enable strobes and 50%-duty divided clocks from one reference clock, using per-channel phase accumulators (NCOs).
- Output frequencies are reprogrammable at run time through a valid/ready config port; `locked` reports when all channels have settled after reset or reconfiguration.
- Feeds the video/audio timing logic in sub_top.

Parameters:
- NUM_CH, 3, number of output channels (1..16).
- ACC_W, 32, phase accumulator / increment width in bits (4..48).
- SETTLE_CYCLES, 1024, refclk cycles `locked` stays low after reset or any applied config write (>=2).
- INIT_INC, {NUM_CH{32'h0}}, flat NUM_CH*ACC_W vector of reset increments; channel i uses bits [i*ACC_W +: ACC_W].
- CH_W, max(1,$clog2(NUM_CH)), width of the channel select (derived, not overridden).

Ports:
- refclk      input   1             sole clock, all logic on its rising edge.
- rst_n       input   1             asynchronous assert, active-low reset.
- cfg_valid   input   1             config write request.
- cfg_ready   output  1             config write accepted when cfg_valid && cfg_ready.
- cfg_ch      input   CH_W          target channel of the write.
- cfg_inc     input   ACC_W         new phase increment.
- cfg_en      input   1             new channel enable.
- outclk_en   output  NUM_CH        one-cycle strobe per channel on accumulator wrap.
- outclk      output  NUM_CH        registered accumulator MSB per channel (divided clock, used as data/enable, not as a clock net).
- locked      output  1             all channels stable.

Behaviour:
- Reset values (while rst_n low):
  - acc[i]=0, inc[i]=INIT_INC slice, en[i]=1.
  - outclk=0, outclk_en=0, locked=0, cfg_ready=0.
  - state=SETTLE, settle counter=0.
- Per channel, every cycle with en[i]=1:
  - {carry, acc[i]} <= acc[i] + inc[i] (ACC_W+1-bit sum, wrap modulo 2^ACC_W).
  - outclk_en[i] <= carry.
  - outclk[i] <= MSB of the new acc[i].
- Latency: a wrap on edge k gives outclk_en[i]=1 for exactly the cycle after edge k.
- Frequency: f_out = f_refclk*inc/2^ACC_W.
  - inc=0 → outputs held 0.
  - inc >= 2^(ACC_W-1) is legal; strobes may assert on consecutive cycles.
- en[i]=0: acc[i] frozen, outclk_en[i]=0, outclk[i]=0.
- State machine:
  - SETTLE: locked=0, cfg_ready=0, counter increments each cycle. When counter == SETTLE_CYCLES-1, go to LOCKED next edge and clear the counter.
  - LOCKED: locked=1, cfg_ready=1. An accepted write (cfg_valid && cfg_ready) with cfg_ch < NUM_CH does, on that edge:
    - inc[cfg_ch] <= cfg_inc, en[cfg_ch] <= cfg_en, acc[cfg_ch] <= 0, outclk[cfg_ch] <= 0, outclk_en[cfg_ch] <= 0.
    - state -> SETTLE, counter=0, so locked=0 from the next cycle.
  - Other channels keep running undisturbed during any write.
- Accepted write with cfg_ch >= NUM_CH: consumed, no register change, stays LOCKED.
- cfg_valid while cfg_ready=0: ignored. The requester holds its request; no buffering.
- `locked` first rises on the SETTLE_CYCLES-th rising edge after rst_n deasserts.
- rst_n asserted mid-operation: all registers return to reset values immediately. Reprogrammed increments are lost (INIT_INC restored).
- Reset deassertion is synchronised upstream; the block uses rst_n directly.

Test Plan:
- Reset, ACC_W=8, NUM_CH=3, SETTLE_CYCLES=16, INIT_INC={8'd0,8'd128,8'd64}, release rst_n → locked=0 for 15 edges, 1 on the 16th. ch0: outclk pattern 0,0,1,1 repeating, outclk_en once every 4 cycles. ch1: outclk toggles every cycle, outclk_en every 2 cycles. ch2: all 0.
- While LOCKED, write ch=2, inc=32, en=1 → cfg_ready drops the next cycle, locked=0 for 16 cycles. ch2 starts from acc=0: outclk low 4 / high 4 cycles, strobe every 8. ch0 phase is unbroken across the write.
- Write ch=0, en=0 → ch0 outclk/outclk_en held 0. Rewrite en=1, inc=64 → pattern restarts from phase 0.
- Write ch=3 (out of range) → accepted, locked stays 1, no channel changes.
- Hold cfg_valid during SETTLE → no acceptance until LOCKED. The write is taken on the first cycle cfg_ready=1.
- Assert rst_n low mid-SETTLE after reprogramming → outputs 0 asynchronously. After release, INIT_INC behaviour returns and locked rises after 16 edges.
